// File: rtl/prince_ti_pkg.sv
// Shared definitions for the threshold-implemented PRINCE datapath:
// nibble constants, the linear maps of A and A^-1, and share slicing.
package prince_ti_pkg;

    localparam int NIBBLE_W = 4;
    localparam logic [3:0] C_FWD = 4'b0101;
    localparam logic [3:0] C_INV = 4'b1011;

    // Forward linear part L: z0=x1, z1=x0^x1^x2, z2=x3, z3=x2
    function automatic logic [3:0] lin_fwd(input logic [3:0] x);
        return {x[2], x[3], x[0] ^ x[1] ^ x[2], x[1]};
    endfunction

    // Inverse linear part Li: x0=z0^z1^z3, x1=z0, x2=z3, x3=z2
    function automatic logic [3:0] lin_inv(input logic [3:0] z);
        return {z[2], z[3], z[0], z[0] ^ z[1] ^ z[3]};
    endfunction

    // Bit offset of nibble n of share s in a flat multi-share vector
    function automatic int nib_lsb(input int s, input int n,
                                   input int n_nibbles);
        return (s * n_nibbles + n) * NIBBLE_W;
    endfunction

endpackage

// File: rtl/affine_nibble.sv
// Combinational 4-bit affine map; the constant is only added
// when this nibble belongs to share 0.
module affine_nibble
    import prince_ti_pkg::*;
(
    input  logic [3:0] x_i,
    input  logic       mode_i,
    input  logic       add_const_i,
    output logic [3:0] z_o
);

    logic [3:0] lin;
    logic [3:0] cst;

    // Select direction, then optionally fold in the affine constant
    always_comb begin
        lin = mode_i ? lin_inv(x_i) : lin_fwd(x_i);
        cst = mode_i ? C_INV : C_FWD;
        z_o = add_const_i ? (lin ^ cst) : lin;
    end

endmodule

// File: rtl/masked_affine_layer.sv
// Share-wise affine layer between the quadratic S-box stages,
// wrapped in an elastic valid/ready pipeline with flush.
module masked_affine_layer
    import prince_ti_pkg::*;
#(
    parameter int N_SHARES  = 5,
    parameter int N_NIBBLES = 16,
    parameter int STAGES    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_mode,
    input  logic [N_SHARES*NIBBLE_W*N_NIBBLES-1:0] in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  out_mode,
    output logic [N_SHARES*NIBBLE_W*N_NIBBLES-1:0] out_data
);

    localparam int DW = N_SHARES * NIBBLE_W * N_NIBBLES;

    logic [DW-1:0] comb_data;

    for (genvar s = 0; s < N_SHARES; s++) begin : g_share
        for (genvar n = 0; n < N_NIBBLES; n++) begin : g_nib
            localparam int LSB = nib_lsb(s, n, N_NIBBLES);
            affine_nibble u_nib (
                .x_i        (in_data[LSB +: NIBBLE_W]),
                .mode_i     (in_mode),
                .add_const_i(1'(s == 0)),
                .z_o        (comb_data[LSB +: NIBBLE_W])
            );
        end
    end

    logic          v_q    [STAGES];
    logic          v_d    [STAGES];
    logic          mode_q [STAGES];
    logic          mode_d [STAGES];
    logic [DW-1:0] data_q [STAGES];
    logic [DW-1:0] data_d [STAGES];

    logic          src_v  [STAGES];
    logic          src_m  [STAGES];
    logic [DW-1:0] src_d  [STAGES];

    logic [STAGES-1:0] load;
    logic              chain;
    logic              accept;

    assign src_v[0] = accept;
    assign src_m[0] = in_mode;
    assign src_d[0] = comb_data;

    for (genvar i = 1; i < STAGES; i++) begin : g_src
        assign src_v[i] = v_q[i-1];
        assign src_m[i] = mode_q[i-1];
        assign src_d[i] = data_q[i-1];
    end

    // Ready chain: a stage loads if it or any later stage has room
    always_comb begin
        load  = '0;
        chain = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            chain   = chain | ~v_q[i];
            load[i] = chain;
        end
    end

    assign in_ready = load[0] & ~flush;
    assign accept   = in_valid & in_ready;

    // Next state: flush drops valids but leaves data untouched
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            v_d[i]    = v_q[i];
            mode_d[i] = mode_q[i];
            data_d[i] = data_q[i];
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (load[i]) begin
                v_d[i] = src_v[i];
                if (src_v[i]) begin
                    mode_d[i] = src_m[i];
                    data_d[i] = src_d[i];
                end
            end
        end
    end

    // Pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < STAGES; i++) begin
            if (!rst_n) begin
                v_q[i]    <= 1'b0;
                mode_q[i] <= 1'b0;
                data_q[i] <= '0;
            end else begin
                v_q[i]    <= v_d[i];
                mode_q[i] <= mode_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: tb/tb_masked_affine_layer.sv
// Directed and randomized checks of masked_affine_layer against a
// nibble-level model of A / A^-1 and a beat-order scoreboard.
module tb_masked_affine_layer;

    localparam int NS = 5;
    localparam int NN = 16;
    localparam int SW = 4 * NN;
    localparam int DW = NS * SW;
    localparam int DW1 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, in_valid, in_ready, in_mode;
    logic          out_valid, out_ready, out_mode;
    logic [DW-1:0] in_data, out_data;

    logic           flush1, in_valid1, in_ready1, in_mode1;
    logic           out_valid1, out_ready1, out_mode1;
    logic [DW1-1:0] in_data1, out_data1;

    masked_affine_layer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_mode  (in_mode),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_mode (out_mode),
        .out_data (out_data)
    );

    masked_affine_layer #(
        .N_SHARES (3),
        .N_NIBBLES(1),
        .STAGES   (1)
    ) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush1),
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .in_mode  (in_mode1),
        .in_data  (in_data1),
        .out_valid(out_valid1),
        .out_ready(out_ready1),
        .out_mode (out_mode1),
        .out_data (out_data1)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] exp_q  [$];
    logic          expm_q [$];
    logic [DW-1:0] in_q   [$];
    logic          inm_q  [$];
    logic          acc;

    function automatic logic [3:0] a_fwd(logic [3:0] x);
        logic [3:0] z;
        z[0] = x[1];
        z[1] = x[0] ^ x[1] ^ x[2];
        z[2] = x[3];
        z[3] = x[2];
        return z ^ 4'h5;
    endfunction

    function automatic logic [3:0] a_inv(logic [3:0] z);
        logic [3:0] r;
        r = 4'h0;
        for (int v = 0; v < 16; v++)
            if (a_fwd(4'(v)) == z) r = 4'(v);
        return r;
    endfunction

    function automatic logic [3:0] amap(logic [3:0] x, logic m);
        return m ? a_inv(x) : a_fwd(x);
    endfunction

    function automatic logic [DW-1:0] model(logic [DW-1:0] d, logic m);
        logic [DW-1:0] r;
        logic [3:0] x;
        r = '0;
        for (int s = 0; s < NS; s++)
            for (int n = 0; n < NN; n++) begin
                x = d[s*SW + n*4 +: 4];
                if (s == 0) r[s*SW + n*4 +: 4] = amap(x, m);
                else r[s*SW + n*4 +: 4] = amap(x, m) ^ amap(4'h0, m);
            end
        return r;
    endfunction

    function automatic logic [SW-1:0] recon(logic [DW-1:0] d);
        logic [SW-1:0] r;
        r = '0;
        for (int s = 0; s < NS; s++) r ^= d[s*SW +: SW];
        return r;
    endfunction

    function automatic logic [SW-1:0] plain(logic [SW-1:0] x, logic m);
        logic [SW-1:0] r;
        for (int n = 0; n < NN; n++) r[n*4 +: 4] = amap(x[n*4 +: 4], m);
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        expm_q.delete();
        in_q.delete();
        inm_q.delete();
    endtask

    task automatic cyc();
        logic [DW-1:0] e, di;
        logic em, mi;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious", DW'(out_valid), '0);
            end else begin
                e  = exp_q.pop_front();
                em = expm_q.pop_front();
                di = in_q.pop_front();
                mi = inm_q.pop_front();
                chk("data", out_data, e);
                chk("mode", DW'(out_mode), DW'(em));
                chk("recon", DW'(recon(out_data)), DW'(plain(recon(di), mi)));
            end
        end
        if (acc) begin
            exp_q.push_back(model(in_data, in_mode));
            expm_q.push_back(in_mode);
            in_q.push_back(in_data);
            inm_q.push_back(in_mode);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
        chk("drain", DW'(exp_q.size()), '0);
    endtask

    task automatic directed(string tag, logic [DW-1:0] d, logic m,
                            logic [DW-1:0] exp);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, DW'(out_valid), '0);
        @(posedge clk);
        #1;
        chk({tag, "_lat2"}, DW'(out_valid), DW'(1));
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_mode"}, DW'(out_mode), DW'(m));
        @(posedge clk);
        #1;
    endtask

    task automatic stream(int n);
        out_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = rnd_data();
            in_mode  = 1'($urandom());
            cyc();
        end
    endtask

    initial begin
        logic [DW-1:0] e, fwd0;
        logic [DW-1:0] b [4];
        int cnt, bi;

        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_mode    = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        flush1     = 1'b0;
        in_valid1  = 1'b0;
        in_mode1   = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", DW'(out_valid), '0);
        chk("rst_data", out_data, '0);
        chk("rst_mode", DW'(out_mode), '0);
        chk("rst_ready", DW'(in_ready), DW'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        fwd0 = '0;
        fwd0[SW-1:0] = 64'h5555_5555_5555_5555;
        directed("fwd0", '0, 1'b0, fwd0);
        e = '0;
        e[SW-1:0] = 64'hBBBB_BBBB_BBBB_BBBB;
        directed("inv0", '0, 1'b1, e);
        directed("roundtrip", fwd0, 1'b1, '0);

        cnt = 0;
        for (int k = 0; k < 5000 && cnt < 1000; k++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            in_data   = rnd_data();
            in_mode   = 1'($urandom());
            out_ready = $urandom_range(0, 4) != 0;
            cyc();
            if (acc) cnt++;
        end
        chk("rand_count", DW'(cnt), DW'(1000));
        drain();

        for (int k = 0; k < 4; k++) b[k] = rnd_data();
        out_ready = 1'b0;
        bi = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = bi < 4;
            in_data  = b[bi < 4 ? bi : 0];
            in_mode  = 1'b0;
            cyc();
            chk("bp_accept", DW'(acc), DW'(c < 2 ? 1 : 0));
            if (acc) bi++;
            chk("bp_valid", DW'(out_valid), DW'(c >= 1 ? 1 : 0));
            if (c >= 1) chk("bp_hold", out_data, model(b[0], 1'b0));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && bi < 4; k++) begin
            in_valid = 1'b1;
            in_data  = b[bi];
            in_mode  = 1'b0;
            cyc();
            if (acc) bi++;
        end
        chk("bp_sent", DW'(bi), DW'(4));
        drain();

        stream(3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = rnd_data();
        @(negedge clk);
        chk("flush_ready", DW'(in_ready), '0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", DW'(out_valid), '0);
        clear_sb();
        stream(4);
        drain();

        stream(3);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("mrst_valid", DW'(out_valid), '0);
        chk("mrst_data", out_data, '0);
        chk("mrst_mode", DW'(out_mode), '0);
        chk("mrst_ready", DW'(in_ready), DW'(1));
        rst_n = 1'b1;
        clear_sb();
        stream(4);
        drain();

        in_valid1 = 1'b1;
        in_data1  = 12'hFF0;
        in_mode1  = 1'b0;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        chk("s1_valid", DW'(out_valid1), DW'(1));
        chk("s1_data", DW'(out_data1), DW'(12'hFF5));
        @(posedge clk);
        #1;
        chk("s1_empty", DW'(out_valid1), '0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
